// File: rtl/nibble_serial_subtractor.sv
// nibble_serial_subtractor: a-b-bin one borrow-lookahead nibble per clock; define SUB_SATURATE_EN to clamp underflow to 0
module nibble_serial_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero
);
  localparam int N = WIDTH / 4;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] a_r, b_r, diff_n;
  logic [IW-1:0] idx;
  logic c_r, c1, c2, c3, c4, last;
  logic [3:0] as, bs, g, p, d;
  assign start_ready = state == IDLE;
  assign done_valid = state == DONE;
  assign last = idx == IW'(N - 1);
  always_comb begin
    as = a_r[4*idx +: 4];
    bs = b_r[4*idx +: 4];
    g = ~as & bs;
    p = ~(as ^ bs);
    c1 = g[0] | p[0] & c_r;
    c2 = g[1] | p[1] & g[0] | p[1] & p[0] & c_r;
    c3 = g[2] | p[2] & g[1] | p[2] & p[1] & g[0] | p[2] & p[1] & p[0] & c_r;
    c4 = g[3] | p[3] & g[2] | p[3] & p[2] & g[1] | p[3] & p[2] & p[1] & g[0]
       | p[3] & p[2] & p[1] & p[0] & c_r;
    d = as ^ bs ^ {c3, c2, c1, c_r};
    diff_n = diff;
    diff_n[4*idx +: 4] = d;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      a_r <= '0;
      b_r <= '0;
      diff <= '0;
      bout <= 1'b0;
      zero <= 1'b0;
      idx <= '0;
      c_r <= 1'b0;
    end else if (state == IDLE) begin
      if (start_valid) begin
        a_r <= a;
        b_r <= b;
        c_r <= bin;
        idx <= '0;
        diff <= '0;
        state <= RUN;
      end
    end else if (state == RUN) begin
      diff <= diff_n;
      c_r <= c4;
      idx <= idx + 1'b1;
      if (last) begin
        bout <= c4;
        zero <= diff_n == '0;
        state <= DONE;
`ifdef SUB_SATURATE_EN
        if (c4) begin
          diff <= '0;
          zero <= 1'b1;
        end
`endif
      end
    end else if (done_ready) begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// tb_nibble_serial_subtractor: directed vectors for the 16-bit nibble-serial subtractor
module tb_nibble_serial_subtractor;
  logic clk = 0, reset = 1, start_valid = 0, bin = 0, done_ready = 0;
  logic start_ready, done_valid, bout, zero;
  logic [15:0] a = 0, b = 0, diff;
  int n_cmp = 0, n_err = 0;

  nibble_serial_subtractor #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .start_valid(start_valid), .start_ready(start_ready),
    .a(a), .b(b), .bin(bin), .done_valid(done_valid), .done_ready(done_ready),
    .diff(diff), .bout(bout), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [15:0] ta, input logic [15:0] tb, input logic tbin);
    int w = 0;
    while (!start_ready && w < 20) begin
      tick();
      w++;
    end
    check("ready_wait", {31'd0, start_ready}, 32'd1);
    a = ta;
    b = tb;
    bin = tbin;
    start_valid = 1;
    tick();
    start_valid = 0;
    check("diff_clear", {16'd0, diff}, 32'd0);
  endtask

  task automatic wait_done(input int exp_lat);
    int lat = 0;
    while (!done_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("latency", lat, exp_lat);
  endtask

  task automatic consume();
    done_ready = 1;
    tick();
    done_ready = 0;
    check("ready_back", {31'd0, start_ready}, 32'd1);
  endtask

  task automatic result(input string tag, input logic [15:0] ed, input logic eb, input logic ez);
    check({tag, "_diff"}, {16'd0, diff}, {16'd0, ed});
    check({tag, "_bout"}, {31'd0, bout}, {31'd0, eb});
    check({tag, "_zero"}, {31'd0, zero}, {31'd0, ez});
  endtask

  initial begin
    int cnt;
    tick();
    tick();
    reset = 0;
    check("rst_start_ready", {31'd0, start_ready}, 32'd1);
    check("rst_done_valid", {31'd0, done_valid}, 32'd0);
    result("rst", 16'h0000, 1'b0, 1'b0);

    start_op(16'h1234, 16'h0234, 1'b0);
    wait_done(4);
    result("t1", 16'h1000, 1'b0, 1'b0);
    consume();

    start_op(16'h0000, 16'h0001, 1'b0);
    wait_done(4);
`ifdef SUB_SATURATE_EN
    result("t2", 16'h0000, 1'b1, 1'b1);
`else
    result("t2", 16'hFFFF, 1'b1, 1'b0);
`endif
    consume();

    start_op(16'h8000, 16'h7FFF, 1'b1);
    wait_done(4);
    result("t3", 16'h0000, 1'b0, 1'b1);
    consume();

    start_op(16'h00FF, 16'h000F, 1'b0);
    wait_done(4);
    a = 16'h0010;
    b = 16'h0001;
    start_valid = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_valid", {31'd0, done_valid}, 32'd1);
      check("hold_sready", {31'd0, start_ready}, 32'd0);
      result("hold", 16'h00F0, 1'b0, 1'b0);
    end
    done_ready = 1;
    tick();
    done_ready = 0;
    check("hs_sready", {31'd0, start_ready}, 32'd1);
    check("hs_dvalid", {31'd0, done_valid}, 32'd0);
    tick();
    start_valid = 0;
    check("accept_en2", {31'd0, start_ready}, 32'd0);
    wait_done(4);
    result("t4b", 16'h000F, 1'b0, 1'b0);
    consume();

    start_op(16'h5A5A, 16'h1234, 1'b0);
    start_valid = 1;
    a = 16'hFFFF;
    b = 16'h0000;
    tick();
    check("slice0", {16'd0, diff}, 32'h0006);
    a = 16'h0000;
    b = 16'hFFFF;
    bin = 1;
    tick();
    start_valid = 0;
    wait_done(2);
    result("t5", 16'h4826, 1'b0, 1'b0);
    consume();

    start_op(16'h0000, 16'h0000, 1'b1);
    wait_done(4);
`ifdef SUB_SATURATE_EN
    result("t6", 16'h0000, 1'b1, 1'b1);
`else
    result("t6", 16'hFFFF, 1'b1, 1'b0);
`endif
    consume();

    start_op(16'hFFFF, 16'h0001, 1'b0);
    tick();
    reset = 1;
    tick();
    reset = 0;
    check("abort_sready", {31'd0, start_ready}, 32'd1);
    check("abort_dvalid", {31'd0, done_valid}, 32'd0);
    result("abort", 16'h0000, 1'b0, 1'b0);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done_valid) cnt++;
    end
    check("abort_no_done", cnt, 0);
    start_op(16'h0005, 16'h0003, 1'b0);
    wait_done(4);
    result("t7", 16'h0002, 1'b0, 1'b0);
    consume();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/nibble_serial_subtractor.md
# nibble_serial_subtractor

Multi-cycle unsigned subtractor computing `diff = a - b - bin` over a WIDTH-bit datapath, one 4-bit slice per clock. Each slice uses borrow-lookahead, the inverse counterpart of the team's 4-bit carry-lookahead adder. A registered borrow is chained between slices. The block sits behind a valid/ready request port and a valid/ready result port, so it drops into arithmetic pipelines where area matters more than latency.

## Interface
- `WIDTH`, default 16: operand width in bits. Must be a multiple of 4 and at least 4. N = WIDTH/4 is the slice count.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start_valid`  in  1  request valid.
- `start_ready`  out  1  block can accept a request.
- `a`  in  WIDTH  minuend; sampled only on accept.
- `b`  in  WIDTH  subtrahend; sampled only on accept.
- `bin`  in  1  borrow-in; sampled only on accept.
- `done_valid`  out  1  result valid.
- `done_ready`  in  1  consumer accepts the result.
- `diff`  out  WIDTH  difference.
- `bout`  out  1  borrow-out; 1 means `a < b + bin`.
- `zero`  out  1  `diff` equals 0.

## Operation
- FSM states are IDLE, RUN and DONE. `start_ready` = (state == IDLE). `done_valid` = (state == DONE).
- **IDLE.** On `start_valid & start_ready`:
  - latch `a`, `b`, `bin` into internal registers;
  - clear the slice index to 0 and the `diff` register to 0;
  - go to RUN.
- **RUN.** Each cycle processes slice k = index, bits [4k+3:4k]:
  - per bit: g = ~a & b (borrow generate); p = ~(a ^ b) (borrow propagate);
  - borrows inside the slice use full lookahead: c1 = g0 | p0&c0, c2 = g1 | p1&g0 | p1&p0&c0, and so on up to c4;
  - c0 is the registered borrow, seeded from `bin` on accept;
  - each difference bit is d_i = a_i ^ b_i ^ c_i, written into `diff[4k+3:4k]`;
  - c4 is registered as the next c0;
  - index increments. After slice N-1 is written, `bout` ← c4, `zero` ← (final diff == 0), and the state goes to DONE.
- **DONE.** Outputs are held stable until `done_valid & done_ready`, then the state returns to IDLE. `diff`, `bout` and `zero` keep their values in IDLE until the next accept.
- `start_valid` is ignored in RUN and DONE. The latched operands are never disturbed.
- `done_ready` is ignored outside DONE.
- Reset values: state IDLE, `start_ready`=1, `done_valid`=0, `diff`=0, `bout`=0, `zero`=0, index=0, borrow register=0.
- Reset asserted in RUN or DONE aborts the operation. No `done_valid` is produced, and all outputs return to their reset values on the next edge.
- Reset has priority over every handshake in the same cycle.

## Timing
- Accept occurs at edge E0. Slices 0..N-1 are processed at edges E1..EN. `done_valid` is high in the cycle after EN, so latency is N cycles from accept to result valid (4 for WIDTH=16).
- Earliest result handshake is EN+1. IDLE is entered and `start_ready` returns high after that edge. The next accept can occur no earlier than EN+2. Minimum issue interval is N+2 cycles.
- `diff` bits change only during RUN, and only the slice being processed. Intermediate values are visible but not valid while `done_valid`=0.
- There is no combinational path from `start_valid` or `done_ready` to any output.

## Configuration
- `SUB_SATURATE_EN` defined: in the final RUN cycle, if c4 = 1 then `diff` is forced to 0 and `zero` = 1. `bout` still reports 1.
- `SUB_SATURATE_EN` undefined: the result wraps modulo 2^WIDTH. `zero` reflects the wrapped value.

## Test plan
- 0x1234 − 0x0234, `bin`=0 → `diff`=0x1000, `bout`=0, `zero`=0; `done_valid` exactly 4 cycles after accept.
- 0x0000 − 0x0001, `bin`=0 → `diff`=0xFFFF, `bout`=1. With `SUB_SATURATE_EN`: `diff`=0x0000, `zero`=1, `bout`=1.
- 0x8000 − 0x7FFF, `bin`=1 → `diff`=0x0000, `zero`=1, `bout`=0. This exercises a borrow rippling across all slice boundaries.
- `done_ready` low for 5 cycles → `done_valid`, `diff`, `bout`, `zero` held constant. `start_ready` stays 0, and a new `start_valid` with different operands is not accepted. After `done_ready` pulses, the next accept occurs at EN+2.
- `start_valid` toggled with changing `a`/`b` during RUN → result still matches the operands latched at accept.
- `reset` asserted at E2 of an operation → no `done_valid`. Next cycle: `start_ready`=1, `diff`=0, `bout`=0. A following request (0x0005 − 0x0003) → `diff`=0x0002.
